// File: rtl/parking_entry_log.sv
// rtl/parking_entry_log.sv - parking clock, slot allocator and entry-time store
// Stamps cars on entry and presents the stored stamp to the cost block on exit.
`timescale 1ns/1ps
module parking_entry_log #(
  parameter int N_SLOTS     = 8,
  parameter int SLOT_W      = 3,
  parameter int TICK_DIV    = 1000,
  parameter int PRESENT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entry_req,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              entry_ack,
  output logic              entry_nack,
  output logic [SLOT_W-1:0] entry_slot,
  output logic              exit_ack,
  output logic              exit_err,
  output logic [7:0]        Entry_time,
  output logic [7:0]        current_time,
  output logic              cost_valid,
  output logic [SLOT_W:0]   occupancy,
  output logic              full
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int PC_W  = $clog2(PRESENT_CYC + 1);
  localparam int OCC_W = SLOT_W + 1;
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(N_SLOTS);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESENT_CYC);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALLOC     = 3'd1,
    RELEASE   = 3'd2,
    PRESENT   = 3'd3,
    WAIT_DROP = 3'd4
  } state_t;

  state_t              state;
  logic [PS_W-1:0]     prescaler;
  logic [PC_W-1:0]     pcnt;
  logic                svc_exit;
  logic [SLOT_W-1:0]   slot_q;
  logic [N_SLOTS-1:0]  occ;
  logic [7:0]          stamp_mem [N_SLOTS];

  logic                free_found;
  logic [SLOT_W-1:0]   free_idx;
  logic                hit;
  logic [7:0]          hit_stamp;
  logic [7:0]          new_stamp;

  // Scanning downward leaves the lowest free index as the winner.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit        = 1'b0;
    hit_stamp  = 8'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slot_q == SLOT_W'(i) && occ[i]) begin
        hit       = 1'b1;
        hit_stamp = stamp_mem[i];
      end
    end
  end

  // Zero means "no car" to the cost block, so time 0 is recorded as 1.
  assign new_stamp = (current_time == 8'd0) ? 8'd1 : current_time;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      prescaler    <= '0;
      pcnt         <= '0;
      svc_exit     <= 1'b0;
      slot_q       <= '0;
      occ          <= '0;
      for (int i = 0; i < N_SLOTS; i++) stamp_mem[i] <= 8'd0;
      entry_ack    <= 1'b0;
      entry_nack   <= 1'b0;
      entry_slot   <= '0;
      exit_ack     <= 1'b0;
      exit_err     <= 1'b0;
      Entry_time   <= 8'd0;
      current_time <= 8'd0;
      cost_valid   <= 1'b0;
      occupancy    <= '0;
      full         <= 1'b0;
    end else begin
      entry_ack  <= 1'b0;
      entry_nack <= 1'b0;
      exit_ack   <= 1'b0;
      exit_err   <= 1'b0;

      if (prescaler == PS_LAST) begin
        prescaler    <= '0;
        current_time <= current_time + 8'd1;
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end

      case (state)
        IDLE: begin
          if (exit_req) begin
            slot_q   <= exit_slot;
            svc_exit <= 1'b1;
            state    <= RELEASE;
          end else if (entry_req) begin
            svc_exit <= 1'b0;
            state    <= ALLOC;
          end
        end
        ALLOC: begin
          if (free_found) begin
            for (int i = 0; i < N_SLOTS; i++) begin
              if (free_idx == SLOT_W'(i)) begin
                occ[i]       <= 1'b1;
                stamp_mem[i] <= new_stamp;
              end
            end
            occupancy  <= occupancy + OCC_ONE;
            full       <= (occupancy + OCC_ONE) == OCC_FULL;
            entry_slot <= free_idx;
            entry_ack  <= 1'b1;
          end else begin
            entry_nack <= 1'b1;
          end
          state <= WAIT_DROP;
        end
        RELEASE: begin
          if (hit) begin
            for (int i = 0; i < N_SLOTS; i++) begin
              if (slot_q == SLOT_W'(i)) begin
                occ[i]       <= 1'b0;
                stamp_mem[i] <= 8'd0;
              end
            end
            Entry_time <= hit_stamp;
            cost_valid <= 1'b1;
            exit_ack   <= 1'b1;
            occupancy  <= occupancy - OCC_ONE;
            full       <= 1'b0;
            pcnt       <= PC_W'(1);
            state      <= PRESENT;
          end else begin
            exit_err <= 1'b1;
            state    <= WAIT_DROP;
          end
        end
        PRESENT: begin
          // pcnt counts presented cycles including the RELEASE edge.
          if (pcnt == PC_LAST) begin
            Entry_time <= 8'd0;
            cost_valid <= 1'b0;
            state      <= WAIT_DROP;
          end else begin
            pcnt <= pcnt + PC_W'(1);
          end
        end
        WAIT_DROP: begin
          if (!(svc_exit ? exit_req : entry_req)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/parking_entry_log.md
Name: parking_entry_log

Overview:
- Producer side of the parking-cost interface: owns the free-running 8-bit parking clock (current_time) and a per-slot entry-time store.
- Allocates a slot and timestamps a car on entry.
- On exit, presents that slot's stored Entry_time (non-zero) alongside current_time for the downstream cost calculator, then returns Entry_time to 0 ("no car").
- Sits between the gate sensors/controller and the cost block.

Parameters:
- N_SLOTS, 8, number of parking slots (2..16).
- SLOT_W, 3, slot index width; must satisfy 2**SLOT_W >= N_SLOTS.
- TICK_DIV, 1000, clk cycles per parking-time unit (>= 2).
- PRESENT_CYC, 2, cycles Entry_time stays valid after an exit (>= 1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- entry_req  in  1  car at entry gate; level, four-phase handshake
- exit_req  in  1  car at exit gate; level, four-phase handshake
- exit_slot  in  SLOT_W  slot being vacated; sampled with exit_req
- entry_ack  out  1  one-cycle pulse, slot granted
- entry_nack  out  1  one-cycle pulse, lot full, entry refused
- entry_slot  out  SLOT_W  granted slot; held until next grant
- exit_ack  out  1  one-cycle pulse, exit accepted
- exit_err  out  1  one-cycle pulse, exit_slot empty or out of range
- Entry_time  out  8  stored stamp of exiting car during presentation window, else 0
- current_time  out  8  parking clock
- cost_valid  out  1  high while Entry_time is being presented
- occupancy  out  SLOT_W+1  number of occupied slots
- full  out  1  occupancy == N_SLOTS

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; all slots empty; stamp store 0; prescaler 0; FSM=IDLE.
  - Reset mid-transaction aborts it with no ack. After release, a still-high req is treated as a new request.
- Time base:
  - Prescaler counts 0..TICK_DIV-1; at terminal count, current_time increments.
  - current_time wraps 255->0 modulo 256; it runs in every FSM state.
- Stamp rule: stamp = current_time, except current_time==0 stores 1, because 0 means "no car" downstream.
- FSM states: IDLE, ALLOC, RELEASE, PRESENT, WAIT_DROP.
- IDLE:
  - exit_req=1 -> RELEASE. Exit has priority when both reqs are high on the same edge.
  - Else entry_req=1 -> ALLOC.
- ALLOC (one cycle):
  - If not full: take lowest-index free slot, write stamp, set occupied, occupancy+1, entry_slot=index, entry_ack=1.
  - Else entry_nack=1 with no state change.
  - Next state is WAIT_DROP.
- RELEASE (one cycle):
  - If exit_slot < N_SLOTS and occupied: Entry_time=stored stamp, cost_valid=1, exit_ack=1, slot cleared, stamp cleared to 0, occupancy-1; next state PRESENT.
  - Else exit_err=1, Entry_time stays 0; next state WAIT_DROP.
- PRESENT:
  - Hold Entry_time and cost_valid for PRESENT_CYC cycles in total, counted from the RELEASE edge.
  - Then clear Entry_time=0 and cost_valid=0; next state WAIT_DROP.
- WAIT_DROP: stay until the serviced req is low, then IDLE. Any pending other req is served from IDLE afterwards.
- Latency: ack/nack/err is visible 2 rising edges after req is first sampled high in IDLE.
- full and occupancy are registered and updated on the same edge as the ack.
- A car entering at current_time T and exiting at T' presents Entry_time = T (or 1 if T=0). The cost block handles wrap.

Test Plan:
- TICK_DIV=4, PRESENT_CYC=2, reset released, hold 40 cycles -> current_time=10; run to 1024 cycles -> current_time wraps 255->0.
- entry_req at current_time=5 -> entry_ack pulse, entry_slot=0, occupancy=1. Drop req; exit_req slot 0 at current_time=9 -> exit_ack, Entry_time=5, cost_valid for 2 cycles, then Entry_time=0, occupancy=0.
- Fill 8 slots (slots 0..7 ack'd in order), then a 9th entry -> entry_nack, full=1, occupancy stays 8.
- Exit slot 3, then entry -> entry_slot=3 (lowest free).
- Entry at current_time=0 -> stored stamp 1. Exit of empty slot 6 -> exit_err, Entry_time stays 0. Exit_slot=9 with N_SLOTS=8 and SLOT_W=4 -> exit_err.
- entry_req and exit_req rise on the same edge -> exit serviced first; entry ack'd after exit_req drops.
- Assert reset during PRESENT -> Entry_time=0, cost_valid=0, occupancy=0 immediately.
